// File: rtl/sram_pkg.sv
// Shared SRAM bus constants, also used by the SRAM controller.
package sram_pkg;
   localparam int SRAM_DATA_W = 16;
   localparam int SRAM_ADDR_W = 18;
   localparam int UB_MSB      = 15;
   localparam int UB_LSB      = 8;
   localparam int LB_MSB      = 7;
   localparam int LB_LSB      = 0;

   typedef logic [SRAM_DATA_W-1:0] sram_word_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction
endpackage

// File: rtl/sram_responder_if.sv
// Address and active-low strobes of the asynchronous SRAM bus; data stays a plain inout.
interface sram_responder_if;
   import sram_pkg::*;

   logic [SRAM_ADDR_W-1:0] SRAM_ADDR;
   logic                   SRAM_UB_N;
   logic                   SRAM_LB_N;
   logic                   SRAM_WE_N;
   logic                   SRAM_CE_N;
   logic                   SRAM_OE_N;

   modport master (
      output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
   );
   modport slave (
      input  SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
   );
endinterface

// File: rtl/sram_read_pipe.sv
// LAT-deep address/valid delay line for pipelined reads; plain wires when LAT is 0.
module sram_read_pipe #(
   parameter int LAT = 0,
   parameter int AW  = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] in_addr,
   input  logic          in_valid,
   output logic [AW-1:0] out_addr,
   output logic          out_valid
);
   generate
      if (LAT == 0) begin : g_bypass
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst;
         assign out_addr  = in_addr;
         assign out_valid = in_valid;
      end else begin : g_pipe
         logic [AW-1:0]  addr_q [LAT];
         logic [LAT-1:0] valid_q;

         // Valid bits qualify the address stages, so only they need reset.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               valid_q <= {LAT{1'b0}};
            end else begin
               valid_q[0] <= in_valid;
               for (int i = 1; i < LAT; i++) begin
                  valid_q[i] <= valid_q[i-1];
               end
            end
         end

         // Address shift register.
         always_ff @(posedge clk) begin
            addr_q[0] <= in_addr;
            for (int i = 1; i < LAT; i++) begin
               addr_q[i] <= addr_q[i-1];
            end
         end

         assign out_addr  = addr_q[LAT-1];
         assign out_valid = valid_q[LAT-1];
      end
   endgenerate
endmodule

// File: rtl/sram_responder.sv
// Behavioural 16-bit asynchronous SRAM with byte lanes, optional read pipeline,
// saturating access counters and a sticky empty-write flag.
module sram_responder import sram_pkg::*; #(
   parameter int ADDR_BITS = 10,
   parameter int READ_LAT  = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   sram_responder_if.slave        bus,
   inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
   output logic [15:0]            wr_count,
   output logic [15:0]            rd_count,
   output logic                   proto_err
);
   localparam int DEPTH = 1 << ADDR_BITS;

   sram_word_t           mem [DEPTH];
   logic [ADDR_BITS-1:0] idx;
   logic [ADDR_BITS-1:0] out_addr;
   logic                 out_valid;
   logic                 wr_cycle;
   logic                 wr_en;
   logic                 empty_wr;
   logic                 rd_sample;
   logic                 rd_issue;
   logic                 drive;
   sram_word_t           rd_word;
   logic                 unused_addr_hi;

   // Upper address bits alias onto the implemented depth.
   assign idx            = bus.SRAM_ADDR[ADDR_BITS-1:0];
   assign unused_addr_hi = ^(bus.SRAM_ADDR >> ADDR_BITS);

   assign wr_cycle  = !bus.SRAM_CE_N && !bus.SRAM_WE_N;
   assign wr_en     = wr_cycle && (!bus.SRAM_UB_N || !bus.SRAM_LB_N);
   assign empty_wr  = wr_cycle && bus.SRAM_UB_N && bus.SRAM_LB_N;
   assign rd_sample = !bus.SRAM_CE_N && bus.SRAM_WE_N;
   assign rd_issue  = rd_sample && !bus.SRAM_OE_N;

   sram_read_pipe #(.LAT(READ_LAT), .AW(ADDR_BITS)) u_read_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_addr   (idx),
      .in_valid  (rd_sample),
      .out_addr  (out_addr),
      .out_valid (out_valid)
   );

   // Byte-granular storage; contents survive reset but no write lands while rst is high.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         if (!bus.SRAM_UB_N) begin
            mem[idx][UB_MSB:UB_LSB] <= SRAM_DQ[UB_MSB:UB_LSB];
         end
         if (!bus.SRAM_LB_N) begin
            mem[idx][LB_MSB:LB_LSB] <= SRAM_DQ[LB_MSB:LB_LSB];
         end
      end
   end

   // Access counters and sticky protocol flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_count  <= 16'd0;
         rd_count  <= 16'd0;
         proto_err <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_count <= sat_inc(wr_count);
         end
         if (rd_issue) begin
            rd_count <= sat_inc(rd_count);
         end
         if (empty_wr) begin
            proto_err <= 1'b1;
         end
      end
   end

   // Output gating is evaluated against the strobes present when the data emerges.
   always_comb begin
      drive   = !rst && out_valid && !bus.SRAM_CE_N && !bus.SRAM_OE_N && bus.SRAM_WE_N;
      rd_word = mem[out_addr];
      if (bus.SRAM_UB_N) begin
         rd_word[UB_MSB:UB_LSB] = 8'h00;
      end else begin
         rd_word[UB_MSB:UB_LSB] = mem[out_addr][UB_MSB:UB_LSB];
      end
      if (bus.SRAM_LB_N) begin
         rd_word[LB_MSB:LB_LSB] = 8'h00;
      end else begin
         rd_word[LB_MSB:LB_LSB] = mem[out_addr][LB_MSB:LB_LSB];
      end
   end

   assign SRAM_DQ = drive ? rd_word : {SRAM_DATA_W{1'bz}};
endmodule
